ham_word_capture: RTL and testbench
===================================

HAM_WORD_CAPTURE -- requirements
Module: ham_word_capture

Interface
REQ-001 Parameter DEB_CYCLES, default 16: number of consecutive clock cycles a synchronized input must hold its value before it is accepted as stable (valid range 2..2^16-1).
REQ-002 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sw  input  7  raw asynchronous dipswitch codeword, bit order matching the downstream Hamming decoder input e[6:0].
REQ-005 btn  input  1  raw asynchronous capture pushbutton, active-high.
REQ-006 e  output  7  last captured codeword, registered; feeds the decoder input directly.
REQ-007 e_valid  output  1  one-cycle pulse marking a new capture on e.
REQ-008 sw_stable  output  1  high while the synchronized switch word has been unchanged for at least DEB_CYCLES cycles.
REQ-009 pending  output  1  high while a debounced button press is waiting for the switch word to become stable.

Function
REQ-010 sw and btn shall each pass through a two-flop synchronizer before any other logic uses them.
REQ-011 Switch debounce: a counter shall clear on any cycle where synchronized sw differs from its previous-cycle value, otherwise increment, saturating at DEB_CYCLES.
REQ-012 sw_stable shall be high exactly when the switch counter equals DEB_CYCLES, and low in the same cycle a change is detected.
REQ-013 Button debounce FSM states: B_LOW, B_RISE, B_HIGH, B_FALL; reset state B_LOW.
REQ-014 B_LOW -> B_RISE when synchronized btn=1, clearing the button counter.
REQ-015 B_RISE: counter increments while btn=1; btn=0 returns to B_LOW; counter reaching DEB_CYCLES-1 with btn=1 -> B_HIGH and asserts an internal press event for one cycle.
REQ-016 B_HIGH -> B_FALL when btn=0; B_FALL returns to B_HIGH on btn=1, and to B_LOW after DEB_CYCLES consecutive btn=0 cycles.
REQ-017 Exactly one press event per debounced press; holding btn indefinitely generates no further events.
REQ-018 On a press event with sw_stable=1: e takes the debounced switch word and e_valid pulses the next cycle; capture latency = 1 cycle after the press event.
REQ-019 On a press event with sw_stable=0: pending sets; the first later cycle with sw_stable=1 captures the word, pulses e_valid, and clears pending.
REQ-020 A press event while pending=1 shall not be queued; pending stays set and at most one capture results.
REQ-021 e shall hold its value between captures; e_valid shall never be high for two consecutive cycles.
REQ-022 A switch change during B_HIGH or B_FALL shall not trigger a capture.
REQ-023 Counters shall not wrap; all comparisons use counters at least ceil(log2(DEB_CYCLES+1)) bits wide.

Reset
REQ-024 While rst=1 on a clock edge: synchronizers, counters and previous-value register clear to 0, FSM goes to B_LOW, e=7'b0000000, e_valid=0, sw_stable=0, pending=0.
REQ-025 Reset asserted mid-debounce or with pending=1 shall abandon the press; no capture occurs after rst deasserts until a new full press is debounced.
REQ-026 After reset release, sw_stable shall rise no earlier than DEB_CYCLES+2 cycles later, even if sw has been constant.

Verification (DEB_CYCLES=4)
REQ-027 sw=7'b1010101 held from reset, btn high for 10 cycles after sw_stable=1 -> exactly one e_valid pulse, e=7'b1010101.
REQ-028 btn toggles each cycle for 20 cycles (bounce), then held low -> no e_valid, FSM never leaves B_LOW/B_RISE.
REQ-029 sw changes every 2 cycles while btn press debounces -> pending=1, no e_valid; sw then held at 7'b0110011 -> one e_valid once sw_stable rises, e=7'b0110011, pending=0.
REQ-030 Capture 7'b1111111, then change sw to 7'b0000001 without pressing btn -> e remains 7'b1111111, no e_valid.
REQ-031 rst pulsed for 1 cycle while pending=1 -> all outputs 0 the next cycle; sw stable afterwards with btn low -> no e_valid.
REQ-032 Two clean presses separated by a full release, sw=7'b0001111 then 7'b1110000 -> two single-cycle e_valid pulses with e matching each word.

Source files
------------

// File: rtl/ham_word_capture.sv
// Dipswitch codeword capture for a Hamming decoder: synchronizes and debounces
// the switch word and capture button, then latches the word on each clean press.
module ham_word_capture #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sw,
  input  logic       btn,
  output logic [6:0] e,
  output logic       e_valid,
  output logic       sw_stable,
  output logic       pending
);

  localparam int             CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  DEB_MAX  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    B_LOW,
    B_RISE,
    B_HIGH,
    B_FALL
  } btn_state_e;

  logic [6:0]    sw_meta_q, sw_sync_q, sw_prev_q;
  logic          btn_meta_q, btn_sync_q;
  logic [1:0]    sync_vld_q;
  logic [CW-1:0] sw_cnt_q, sw_cnt_d;
  logic          sw_change;

  btn_state_e    b_state_q;
  logic [CW-1:0] b_cnt_q;
  logic          press_q;

  logic [6:0]    e_q;
  logic          e_valid_q, pending_q;
  logic          capture;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_prev_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
      sync_vld_q <= '0;
      sw_cnt_q   <= '0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      sw_prev_q  <= sw_sync_q;
      btn_meta_q <= btn;
      btn_sync_q <= btn_meta_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      sw_cnt_q   <= sw_cnt_d;
    end
  end

  assign sw_change = (sw_sync_q != sw_prev_q);

  // Counter is held clear until the synchronizer carries real samples, so a
  // constant switch word cannot look stable straight out of reset.
  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if (sw_change || !sync_vld_q[1]) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q != DEB_MAX) begin
      sw_cnt_d = sw_cnt_q + CNT_ONE;
    end
  end

  assign sw_stable = (sw_cnt_q == DEB_MAX) && !sw_change;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_state_q <= B_LOW;
      b_cnt_q   <= '0;
      press_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      unique case (b_state_q)
        B_LOW: begin
          if (btn_sync_q) begin
            b_state_q <= B_RISE;
            b_cnt_q   <= '0;
          end
        end
        B_RISE: begin
          if (!btn_sync_q) begin
            b_state_q <= B_LOW;
          end else if (b_cnt_q == DEB_LAST) begin
            b_state_q <= B_HIGH;
            press_q   <= 1'b1;
          end else begin
            b_cnt_q <= b_cnt_q + CNT_ONE;
          end
        end
        B_HIGH: begin
          if (!btn_sync_q) begin
            b_state_q <= B_FALL;
            b_cnt_q   <= CNT_ONE;
          end
        end
        B_FALL: begin
          // The low cycle that entered B_FALL already counts toward release.
          if (btn_sync_q) begin
            b_state_q <= B_HIGH;
          end else if (b_cnt_q == DEB_LAST) begin
            b_state_q <= B_LOW;
          end else begin
            b_cnt_q <= b_cnt_q + CNT_ONE;
          end
        end
        default: b_state_q <= B_LOW;
      endcase
    end
  end

  // A capture is deferred one cycle if e_valid is already high, keeping pulses apart.
  assign capture = (press_q || pending_q) && sw_stable && !e_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q       <= '0;
      e_valid_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      e_valid_q <= 1'b0;
      if (capture) begin
        e_q       <= sw_sync_q;
        e_valid_q <= 1'b1;
        pending_q <= 1'b0;
      end else if (press_q) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign e       = e_q;
  assign e_valid = e_valid_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_ham_word_capture.sv
// Directed bench for ham_word_capture with DEB_CYCLES=4; expected values are
// hand-derived from the switch/button stimulus of each scenario.
module tb_ham_word_capture;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] sw;
  logic       btn;
  logic [6:0] e;
  logic       e_valid;
  logic       sw_stable;
  logic       pending;

  int total = 0;
  int bad   = 0;
  int vcount = 0;
  int consec = 0;
  logic prev_ev = 1'b0;
  int v0;

  always #5 clk = ~clk;

  ham_word_capture #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn       (btn),
    .e         (e),
    .e_valid   (e_valid),
    .sw_stable (sw_stable),
    .pending   (pending)
  );

  // Pulse counter and back-to-back detector, sampled mid-cycle.
  always @(negedge clk) begin
    if (e_valid === 1'b1) begin
      vcount++;
      if (prev_ev === 1'b1) consec++;
    end
    prev_ev = e_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn = 1'b1;
    tick(10);
    btn = 1'b0;
    tick(10);
  endtask

  task automatic wait_stable();
    for (int i = 0; i < 20 && sw_stable !== 1'b1; i++) tick(1);
  endtask

  initial begin
    rst = 1'b1;
    sw  = 7'b1010101;
    btn = 1'b0;
    tick(3);
    check("rst_e",         32'(e),         32'h0);
    check("rst_e_valid",   32'(e_valid),   32'h0);
    check("rst_sw_stable", 32'(sw_stable), 32'h0);
    check("rst_pending",   32'(pending),   32'h0);

    // sw_stable may not rise within DEB+1 cycles of reset release.
    rst = 1'b0;
    for (int k = 1; k <= DEB + 1; k++) begin
      tick(1);
      check("stable_early", 32'(sw_stable), 32'h0);
    end
    wait_stable();
    check("stable_rise", 32'(sw_stable), 32'h1);

    // Single long press with a stable word.
    v0 = vcount;
    press();
    check("hold_count",   32'(vcount - v0), 32'h1);
    check("hold_e",       32'(e),           32'h55);
    check("hold_pending", 32'(pending),     32'h0);

    // Bouncing button never debounces.
    v0 = vcount;
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      tick(1);
    end
    btn = 1'b0;
    tick(10);
    check("bounce_count",   32'(vcount - v0), 32'h0);
    check("bounce_pending", 32'(pending),     32'h0);
    check("bounce_e",       32'(e),           32'h55);

    // Press while the switch word keeps changing, then settles.
    v0 = vcount;
    for (int i = 0; i < 12; i++) begin
      sw = (i % 2 == 0) ? 7'h11 : 7'h22;
      if (i == 1) btn = 1'b1;
      tick(2);
    end
    check("unst_pending", 32'(pending),     32'h1);
    check("unst_count",   32'(vcount - v0), 32'h0);
    sw = 7'b0110011;
    for (int i = 0; i < 20 && vcount == v0; i++) tick(1);
    tick(1);
    check("settle_count",   32'(vcount - v0), 32'h1);
    check("settle_e",       32'(e),           32'h33);
    check("settle_pending", 32'(pending),     32'h0);
    btn = 1'b0;
    tick(10);

    // Capture all-ones, then a switch change without a press.
    sw = 7'b1111111;
    tick(3);
    wait_stable();
    v0 = vcount;
    press();
    check("ones_count", 32'(vcount - v0), 32'h1);
    check("ones_e",     32'(e),           32'h7f);
    v0 = vcount;
    sw = 7'b0000001;
    tick(15);
    check("nopress_count", 32'(vcount - v0), 32'h0);
    check("nopress_e",     32'(e),           32'h7f);

    // Reset while a press is pending abandons it.
    for (int i = 0; i < 8; i++) begin
      sw = (i % 2 == 0) ? 7'h0c : 7'h30;
      if (i == 1) btn = 1'b1;
      tick(2);
    end
    check("pre_rst_pending", 32'(pending), 32'h1);
    rst = 1'b1;
    btn = 1'b0;
    tick(1);
    check("mid_rst_e",         32'(e),         32'h0);
    check("mid_rst_e_valid",   32'(e_valid),   32'h0);
    check("mid_rst_sw_stable", 32'(sw_stable), 32'h0);
    check("mid_rst_pending",   32'(pending),   32'h0);
    rst = 1'b0;
    sw  = 7'h55;
    v0  = vcount;
    tick(20);
    check("post_rst_count",   32'(vcount - v0), 32'h0);
    check("post_rst_e",       32'(e),           32'h0);
    check("post_rst_pending", 32'(pending),     32'h0);

    // Two clean presses with different words.
    sw = 7'b0001111;
    tick(3);
    wait_stable();
    v0 = vcount;
    press();
    check("two_a_count", 32'(vcount - v0), 32'h1);
    check("two_a_e",     32'(e),           32'h0f);
    sw = 7'b1110000;
    tick(3);
    wait_stable();
    v0 = vcount;
    press();
    check("two_b_count", 32'(vcount - v0), 32'h1);
    check("two_b_e",     32'(e),           32'h70);

    check("ev_back_to_back", 32'(consec), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
